// File: rtl/multicycle_processor.sv
// multicycle_processor
//   Two-phase (FETCH/EXEC) processor with a HALT idle state, host program
//   load port and run/step/stop control. Instruction word layout:
//   {opcode[4], Rx[RW], Ry[RW], imm[DATA_W]}.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, step       leave HALT: free-run / single instruction
//   stop              finish the current instruction, then HALT
//   prog_we/addr/data instruction-memory write port, honoured in HALT only
//   disp_sel/data     combinational read of R[disp_sel]
//   pc                current program counter
//   halted            high while in HALT
//   retire            one-cycle pulse after each executed instruction
module multicycle_processor #(
  parameter  int DATA_W    = 8,
  parameter  int NUM_REGS  = 4,
  parameter  int MEM_DEPTH = 64,
  localparam int RW        = $clog2(NUM_REGS),
  localparam int PC_W      = $clog2(MEM_DEPTH),
  localparam int INSTR_W   = 4 + 2*RW + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step,
  input  logic               stop,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [RW-1:0]      disp_sel,
  output logic [DATA_W-1:0]  disp_data,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               retire
);

  localparam logic [3:0] OP_LOAD = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_LDPC = 4'h4;
  localparam logic [3:0] OP_BRNZ = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {S_HALT, S_FETCH, S_EXEC} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic               r_retire;
  logic               r_step_mode;
  logic               r_stop_pend;
  logic [DATA_W-1:0]  r_regs [NUM_REGS];
  logic [INSTR_W-1:0] r_mem  [MEM_DEPTH];

  logic [3:0]         w_op;
  logic [RW-1:0]      w_rx;
  logic [RW-1:0]      w_ry;
  logic [DATA_W-1:0]  w_imm;
  logic [DATA_W-1:0]  w_rx_val;
  logic [DATA_W-1:0]  w_ry_val;
  logic               w_taken;
  logic               w_terminate;
  logic [PC_W-1:0]    w_pc_next;
  logic               w_wr_en;
  logic [DATA_W-1:0]  w_wr_data;

  // Decode of the held instruction
  assign w_op     = r_ir[INSTR_W-1 -: 4];
  assign w_rx     = r_ir[DATA_W+RW +: RW];
  assign w_ry     = r_ir[DATA_W +: RW];
  assign w_imm    = r_ir[DATA_W-1:0];
  assign w_rx_val = r_regs[w_rx];
  assign w_ry_val = r_regs[w_ry];

  assign w_taken     = (w_op == OP_BRNZ) && (w_rx_val != '0);
  assign w_terminate = (w_op == OP_HALT) || r_step_mode || r_stop_pend;
  // Casts zero-extend or truncate between register and PC widths
  assign w_pc_next   = w_taken ? PC_W'(w_ry_val) : r_pc + PC_W'(1);

  // Result selection; operands are read before the write, so Rx == Ry is safe
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_data = '0;
    case (w_op)
      OP_LOAD: begin w_wr_en = 1'b1; w_wr_data = w_imm;               end
      OP_MOV:  begin w_wr_en = 1'b1; w_wr_data = w_ry_val;            end
      OP_ADD:  begin w_wr_en = 1'b1; w_wr_data = w_rx_val + w_ry_val; end
      OP_XOR:  begin w_wr_en = 1'b1; w_wr_data = w_rx_val ^ w_ry_val; end
      OP_LDPC: begin w_wr_en = 1'b1; w_wr_data = DATA_W'(r_pc);       end
      OP_SUB:  begin w_wr_en = 1'b1; w_wr_data = w_rx_val - w_ry_val; end
      default: ;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_HALT;
    else     r_state <= w_next_state;
  end

  // FSM: next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_HALT:  if (start || step) w_next_state = S_FETCH;
      S_FETCH: w_next_state = S_EXEC;
      S_EXEC:  w_next_state = w_terminate ? S_HALT : S_FETCH;
      default: w_next_state = S_HALT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    halted    = (r_state == S_HALT);
    retire    = r_retire;
    pc        = r_pc;
    disp_data = r_regs[disp_sel];
  end

  // Instruction memory is not reset so a loaded program survives rst
  always_ff @(posedge clk) begin
    if (r_state == S_HALT && prog_we) r_mem[prog_addr] <= prog_data;
  end

  // Control and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= '0;
      r_ir        <= '0;
      r_retire    <= 1'b0;
      r_step_mode <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      r_retire <= (r_state == S_EXEC);
      case (r_state)
        S_HALT: begin
          // start has priority over step
          if (start)     r_step_mode <= 1'b0;
          else if (step) r_step_mode <= 1'b1;
        end
        S_FETCH: begin
          r_ir <= r_mem[r_pc];
          if (stop) r_stop_pend <= 1'b1;
        end
        S_EXEC: begin
          r_pc <= w_pc_next;
          if (w_terminate) r_stop_pend <= 1'b0;
          else if (stop)   r_stop_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (r_state == S_EXEC && w_wr_en) begin
      r_regs[w_rx] <= w_wr_data;
    end
  end

endmodule

// File: tb/tb_multicycle_processor.sv
`timescale 1ns/1ps
module tb_multicycle_processor;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MD = 64;
  localparam int RW = 2;
  localparam int PW = 6;
  localparam int IW = 4 + 2*RW + DW;

  localparam int DW2 = 16;
  localparam int NR2 = 8;
  localparam int RW2 = 3;
  localparam int IW2 = 4 + 2*RW2 + DW2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, step = 1'b0, stop = 1'b0, prog_we = 1'b0;
  logic [PW-1:0] prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic [RW-1:0] disp_sel = '0;
  logic [DW-1:0] disp_data;
  logic [PW-1:0] pc;
  logic          halted, retire;

  logic           p_start = 1'b0, p_step = 1'b0, p_stop = 1'b0, p_prog_we = 1'b0;
  logic [PW-1:0]  p_prog_addr = '0;
  logic [IW2-1:0] p_prog_data = '0;
  logic [RW2-1:0] p_disp_sel = '0;
  logic [DW2-1:0] p_disp_data;
  logic [PW-1:0]  p_pc;
  logic           p_halted, p_retire;

  always #10 clk = ~clk;

  multicycle_processor #(.DATA_W(DW), .NUM_REGS(NR), .MEM_DEPTH(MD)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .stop(stop),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .disp_sel(disp_sel), .disp_data(disp_data), .pc(pc),
    .halted(halted), .retire(retire));

  multicycle_processor #(.DATA_W(DW2), .NUM_REGS(NR2), .MEM_DEPTH(MD)) dut16 (
    .clk(clk), .rst(rst), .start(p_start), .step(p_step), .stop(p_stop),
    .prog_we(p_prog_we), .prog_addr(p_prog_addr), .prog_data(p_prog_data),
    .disp_sel(p_disp_sel), .disp_data(p_disp_data), .pc(p_pc),
    .halted(p_halted), .retire(p_retire));

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model: ISA-level interpreter ----------------
  int mdl_mem  [MD];
  int mdl_regs [NR];
  int mdl_pc;

  task automatic mdl_reset();
    for (int r = 0; r < NR; r++) mdl_regs[r] = 0;
    mdl_pc = 0;
  endtask

  task automatic mdl_exec_one(output bit is_halt);
    int w, op, rx, ry, imm, a, b, nxt;
    w   = mdl_mem[mdl_pc];
    op  = w / (1 << (IW - 4));
    rx  = (w / (1 << (DW + RW))) % NR;
    ry  = (w / (1 << DW)) % NR;
    imm = w % (1 << DW);
    a   = mdl_regs[rx];
    b   = mdl_regs[ry];
    nxt = (mdl_pc + 1) % MD;
    case (op)
      0: mdl_regs[rx] = imm;
      1: mdl_regs[rx] = b;
      2: mdl_regs[rx] = (a + b) % 256;
      3: mdl_regs[rx] = a ^ b;
      4: mdl_regs[rx] = mdl_pc % 256;
      5: if (a != 0) nxt = b % MD;
      6: mdl_regs[rx] = (a - b + 256) % 256;
      default: ;
    endcase
    is_halt = (op == 15);
    mdl_pc  = nxt;
  endtask

  task automatic mdl_run(output int n);
    bit h;
    n = 0;
    h = 1'b0;
    while (!h && n < 2000) begin
      mdl_exec_one(h);
      n++;
    end
  endtask

  function automatic logic [IW-1:0] enc(input int op, input int rx, input int ry, input int imm);
    return {4'(op), RW'(rx), RW'(ry), DW'(imm)};
  endfunction

  // ---------------- bench helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int addr, input logic [IW-1:0] data);
    prog_we   = 1'b1;
    prog_addr = PW'(addr);
    prog_data = data;
    @(negedge clk);
    prog_we   = 1'b0;
    mdl_mem[addr] = int'(data);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
  endtask

  task automatic pulse(input logic s, input logic st);
    start = s;
    step  = st;
    @(negedge clk);
    start = 1'b0;
    step  = 1'b0;
    check("halted_fell", halted, 1'b0);
  endtask

  task automatic run_to_halt(output int cyc, output int ret);
    cyc = 0;
    ret = 0;
    while (halted !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (retire === 1'b1) ret++;
    end
    check("halt_reached", halted, 1'b1);
    check("retire_with_halt", retire, 1'b1);
  endtask

  task automatic check_regs(input string tag);
    for (int r = 0; r < NR; r++) begin
      disp_sel = RW'(r);
      #1;
      check($sformatf("%s_R%0d", tag, r), disp_data, mdl_regs[r]);
    end
  endtask

  task automatic load_demo();
    load(0, enc(0, 0, 0, 5));
    load(1, enc(0, 1, 0, 10));
    load(2, enc(2, 0, 1, 0));
    load(3, enc(1, 2, 0, 0));
    load(4, enc(0, 3, 0, 8'hAA));
    load(5, enc(3, 2, 3, 0));
    load(6, enc(15, 0, 0, 0));
  endtask

  initial begin
    int cyc, ret, n;
    bit h;

    // Reset state
    mdl_reset();
    repeat (2) @(negedge clk);
    check("rst_halted", halted, 1'b1);
    check("rst_pc", pc, 0);
    check("rst_retire", retire, 1'b0);
    check_regs("rst");
    rst = 1'b0;
    @(negedge clk);
    $display("reset: halted=%0b pc=%0d", halted, pc);

    // Demo program, free-run
    load_demo();
    pulse(1'b1, 1'b0);
    run_to_halt(cyc, ret);
    mdl_run(n);
    check("demo_cycles", cyc, 14);
    check("demo_retires", ret, 7);
    check("demo_pc", pc, 7);
    check("demo_mdl_pc", pc, mdl_pc);
    check_regs("demo");
    disp_sel = 2'd2; #1; check("demo_R2_const", disp_data, 8'hA5);
    disp_sel = 2'd0; #1; check("demo_R0_const", disp_data, 8'h0F);
    $display("demo: cycles=%0d retires=%0d pc=%0d", cyc, ret, pc);

    // Single-step three instructions
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pulse(1'b0, 1'b1);
      run_to_halt(cyc, ret);
      mdl_exec_one(h);
      check("step_retires", ret, 1);
      check("step_cycles", cyc, 2);
      repeat (3) @(negedge clk);
      check("step_stays_halted", halted, 1'b1);
      check("step_pc", pc, mdl_pc);
      $display("step %0d: pc=%0d retires=%0d", k, pc, ret);
    end
    disp_sel = 2'd0; #1; check("step_R0", disp_data, 8'h0F);
    check_regs("step");

    // Stop during the third instruction's FETCH; program write while running
    do_reset();
    pulse(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    stop      = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 6'd6;
    prog_data = enc(0, 0, 0, 8'h33);
    @(negedge clk);
    stop    = 1'b0;
    prog_we = 1'b0;
    run_to_halt(cyc, ret);
    for (int k = 0; k < 3; k++) mdl_exec_one(h);
    check("stop_pc", pc, 3);
    check_regs("stop");
    $display("stop: pc=%0d", pc);

    // Memory unchanged by the running write; start+step together free-runs
    do_reset();
    pulse(1'b1, 1'b1);
    run_to_halt(cyc, ret);
    mdl_run(n);
    check("both_retires", ret, 7);
    check("both_pc", pc, 7);
    check_regs("both");
    $display("start+step: retires=%0d pc=%0d", ret, pc);

    // Asynchronous reset in the middle of an EXEC
    do_reset();
    pulse(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    mdl_reset();
    check("rstx_halted", halted, 1'b1);
    check("rstx_pc", pc, 0);
    check("rstx_retire", retire, 1'b0);
    check_regs("rstx");
    @(negedge clk);
    rst = 1'b0;
    $display("reset in EXEC: halted=%0b pc=%0d", halted, pc);

    // Countdown loop
    load(0, enc(0, 0, 0, 3));
    load(1, enc(0, 1, 0, 1));
    load(2, enc(0, 2, 0, 3));
    load(3, enc(6, 0, 1, 0));
    load(4, enc(5, 0, 2, 0));
    load(5, enc(15, 0, 0, 0));
    do_reset();
    pulse(1'b1, 1'b0);
    run_to_halt(cyc, ret);
    mdl_run(n);
    check("loop_retires", ret, n);
    check("loop_retires_const", ret, 10);
    check("loop_pc", pc, 6);
    check_regs("loop");
    $display("loop: retires=%0d pc=%0d", ret, pc);

    // PC wrap: step to pc=MD-1, then NOP there and HALT at 0
    load(0, enc(0, 0, 0, 1));
    load(1, enc(0, 1, 0, MD - 1));
    load(2, enc(5, 0, 1, 0));
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pulse(1'b0, 1'b1);
      run_to_halt(cyc, ret);
      mdl_exec_one(h);
    end
    check("wrap_setup_pc", pc, MD - 1);
    for (int a = 0; a < MD; a++) load(a, enc(7 + (a % 8), 0, 0, a));
    load(0, enc(15, 0, 0, 0));
    pulse(1'b1, 1'b0);
    run_to_halt(cyc, ret);
    mdl_run(n);
    check("wrap_retires", ret, 2);
    check("wrap_pc", pc, 1);
    check_regs("wrap");
    $display("wrap: retires=%0d pc=%0d", ret, pc);

    // Random straight-line programs against the model
    for (int t = 0; t < 6; t++) begin
      int len, op;
      len = $urandom_range(20, 6);
      for (int a = 0; a < len; a++) begin
        op = $urandom_range(14, 0);
        if (op == 5) op = 6;
        load(a, enc(op, $urandom_range(NR - 1, 0), $urandom_range(NR - 1, 0), $urandom_range(255, 0)));
      end
      load(len, enc(15, 0, 0, 0));
      do_reset();
      pulse(1'b1, 1'b0);
      run_to_halt(cyc, ret);
      mdl_run(n);
      check("rand_retires", ret, n);
      check("rand_cycles", cyc, 2 * n);
      check("rand_pc", pc, mdl_pc);
      check_regs("rand");
      $display("random %0d: len=%0d retires=%0d pc=%0d", t, len, ret, pc);
    end

    // 16-bit, 8-register variant
    begin
      logic [IW2-1:0] prog2 [4];
      prog2[0] = {4'h0, 3'd7, 3'd0, 16'hFFFF};
      prog2[1] = {4'h0, 3'd6, 3'd0, 16'h0001};
      prog2[2] = {4'h2, 3'd7, 3'd6, 16'h0000};
      prog2[3] = {4'hF, 3'd0, 3'd0, 16'h0000};
      for (int a = 0; a < 4; a++) begin
        p_prog_we   = 1'b1;
        p_prog_addr = PW'(a);
        p_prog_data = prog2[a];
        @(negedge clk);
      end
      p_prog_we = 1'b0;
      p_start   = 1'b1;
      @(negedge clk);
      p_start = 1'b0;
      cyc = 0;
      while (p_halted !== 1'b1 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check("w16_halted", p_halted, 1'b1);
      check("w16_cycles", cyc, 8);
      check("w16_pc", p_pc, 4);
      p_disp_sel = 3'd7; #1; check("w16_R7", p_disp_data, 16'h0000);
      p_disp_sel = 3'd6; #1; check("w16_R6", p_disp_data, 16'h0001);
      $display("w16: cycles=%0d pc=%0d", cyc, p_pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
